// File: rtl/top_level_miner_if.sv
`default_nettype none
// ============================================================================
// Module   : top_level_miner_if
// Purpose  : 32-bit register slave bus of the proof-of-work miner.
// Revision : 1.0 - initial release
// ============================================================================
interface top_level_miner_if;
  logic [4:0]  slaveAddr;
  logic [31:0] slaveWriteData;
  logic        slaveWrite;
  logic        slaveRead;
  logic        slaveChipSelect;
  logic [31:0] slaveReadData;

  modport master (
    output slaveAddr, slaveWriteData, slaveWrite, slaveRead, slaveChipSelect,
    input  slaveReadData
  );

  modport slave (
    input  slaveAddr, slaveWriteData, slaveWrite, slaveRead, slaveChipSelect,
    output slaveReadData
  );
endinterface
`default_nettype wire

// File: rtl/top_level_miner.sv
`default_nettype none
// ============================================================================
// Module   : top_level_miner
// Purpose  : Double-SHA-256 nonce search engine behind a register slave port.
//            Optional hash counter on addr 30 enabled by MINER_HASHCOUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module top_level_miner #(
  parameter logic [31:0] MAX_NONCE = 32'hFFFF_FFFF
) (
  input wire               clk,
  input wire               n_rst,
  top_level_miner_if.slave bus
);

  localparam logic [2:0] c_idle      = 3'd0;
  localparam logic [2:0] c_midstate  = 3'd1;
  localparam logic [2:0] c_blk2      = 3'd2;
  localparam logic [2:0] c_hash2     = 3'd3;
  localparam logic [2:0] c_cmp       = 3'd4;
  localparam logic [2:0] c_found     = 3'd5;
  localparam logic [2:0] c_exhausted = 3'd6;

  localparam logic [7:0][31:0] c_h0 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] c_k [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Word [0] is W0; the schedule window shifts toward index 0 each round.
  function automatic logic [15:0][31:0] blk1(input logic [607:0] m);
    logic [15:0][31:0] b;
    for (int i = 0; i < 16; i++) b[i] = m[607 - 32*i -: 32];
    return b;
  endfunction

  function automatic logic [15:0][31:0] blk2(input logic [607:0] m, input logic [31:0] n);
    logic [15:0][31:0] b;
    b     = '0;
    b[0]  = m[95:64];
    b[1]  = m[63:32];
    b[2]  = m[31:0];
    b[3]  = {n[7:0], n[15:8], n[23:16], n[31:24]};
    b[4]  = 32'h8000_0000;
    b[15] = 32'd640;
    return b;
  endfunction

  function automatic logic [15:0][31:0] hblk(input logic [7:0][31:0] d);
    logic [15:0][31:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[i] = d[i];
    b[8]  = 32'h8000_0000;
    b[15] = 32'd256;
    return b;
  endfunction

  // Digest byte j lands at integer byte j, so the last digest byte is the MSB.
  function automatic logic [255:0] bswap(input logic [7:0][31:0] d);
    logic [255:0] h;
    for (int w = 0; w < 8; w++)
      for (int b = 0; b < 4; b++) h[8*(4*w + b) +: 8] = d[w][31 - 8*b -: 8];
    return h;
  endfunction

  logic [255:0]      r_tgt_stg, r_target;
  logic [607:0]      r_msg_stg, r_msg;
  logic [7:0][31:0]  r_v, r_mid, r_dig, w_fin;
  logic [15:0][31:0] r_w;
  logic [6:0]        r_round;
  logic [2:0]        r_state;
  logic [31:0]       r_nonce, r_result, r_rdata, w_rdata;
  logic [31:0]       w_t1, w_t2, w_wnext;
  logic [1:0]        w_status;
  logic [2:0]        w_toff;
  logic [4:0]        w_moff;
  logic              w_wr, w_rd, w_start, w_hit;

  assign w_wr    = bus.slaveChipSelect & bus.slaveWrite;
  assign w_rd    = bus.slaveChipSelect & bus.slaveRead;
  assign w_start = w_wr && (bus.slaveAddr == 5'd1) && (bus.slaveWriteData == 32'd2);
  assign w_toff  = bus.slaveAddr[2:0] - 3'd2;
  assign w_moff  = bus.slaveAddr - 5'd11;

  assign w_t1 = r_v[7] + bsig1(r_v[4]) + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6]))
              + c_k[r_round[5:0]] + r_w[0];
  assign w_t2 = bsig0(r_v[0]) + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
  assign w_wnext = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];
  assign w_hit   = bswap(r_dig) < r_target;

  always_comb begin
    w_fin = '0;
    for (int i = 0; i < 8; i++)
      w_fin[i] = r_v[i] + ((r_state == c_blk2) ? r_mid[i] : c_h0[i]);
  end

  always_comb begin
    w_status = 2'd2;
    case (r_state)
      c_idle:      w_status = 2'd0;
      c_found:     w_status = 2'd3;
      c_exhausted: w_status = 2'd1;
      default:     w_status = 2'd2;
    endcase
  end

`ifdef MINER_HASHCOUNT_EN
  logic [31:0] r_hcount;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                   r_hcount <= '0;
    else if (w_start)                             r_hcount <= '0;
    else if (r_state == c_cmp && r_hcount != '1)  r_hcount <= r_hcount + 32'd1;
  end
`endif

  always_comb begin
    w_rdata = '0;
    if (bus.slaveAddr == 5'd0)       w_rdata = {30'd0, w_status};
    else if (bus.slaveAddr >= 5'd2 && bus.slaveAddr <= 5'd9)
      w_rdata = r_tgt_stg[{w_toff, 5'b0} +: 32];
    else if (bus.slaveAddr == 5'd10) w_rdata = r_result;
    else if (bus.slaveAddr >= 5'd11 && bus.slaveAddr <= 5'd29)
      w_rdata = r_msg_stg[{w_moff, 5'b0} +: 32];
`ifdef MINER_HASHCOUNT_EN
    else if (bus.slaveAddr == 5'd30) w_rdata = r_hcount;
`endif
  end

  assign bus.slaveReadData = r_rdata;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_tgt_stg <= '0;  r_target <= '0;  r_msg_stg <= '0;  r_msg   <= '0;
      r_v       <= '0;  r_mid    <= '0;  r_dig     <= '0;  r_w     <= '0;
      r_round   <= '0;  r_nonce  <= '0;  r_result  <= '0;  r_rdata <= '0;
      r_state   <= c_idle;
    end else begin
      if (w_rd) r_rdata <= w_rdata;
      if (w_wr) begin
        if (bus.slaveAddr >= 5'd2 && bus.slaveAddr <= 5'd9)
          r_tgt_stg[{w_toff, 5'b0} +: 32] <= bus.slaveWriteData;
        if (bus.slaveAddr >= 5'd11 && bus.slaveAddr <= 5'd29)
          r_msg_stg[{w_moff, 5'b0} +: 32] <= bus.slaveWriteData;
        if (bus.slaveAddr == 5'd1 && bus.slaveWriteData == 32'd1)
          r_target <= r_tgt_stg;
      end
      case (r_state)
        c_midstate, c_blk2, c_hash2: begin
          if (!r_round[6]) begin
            r_v[0] <= w_t1 + w_t2;  r_v[1] <= r_v[0];  r_v[2] <= r_v[1];  r_v[3] <= r_v[2];
            r_v[4] <= r_v[3] + w_t1; r_v[5] <= r_v[4]; r_v[6] <= r_v[5];  r_v[7] <= r_v[6];
            r_w     <= {w_wnext, r_w[15:1]};
            r_round <= r_round + 7'd1;
          end else begin
            // 65th cycle of a compression folds in the chaining value.
            r_round <= '0;
            if (r_state == c_midstate) begin
              r_mid <= w_fin;  r_v <= w_fin;  r_w <= blk2(r_msg, r_nonce);
              r_state <= c_blk2;
            end else if (r_state == c_blk2) begin
              r_v <= c_h0;  r_w <= hblk(w_fin);
              r_state <= c_hash2;
            end else begin
              r_dig <= w_fin;
              r_state <= c_cmp;
            end
          end
        end
        c_cmp: begin
          if (w_hit) begin
            r_result <= r_nonce;
            r_state  <= c_found;
          end else if (r_nonce == MAX_NONCE) begin
            r_state  <= c_exhausted;
          end else begin
            r_nonce <= r_nonce + 32'd1;
            r_v     <= r_mid;
            r_w     <= blk2(r_msg, r_nonce + 32'd1);
            r_state <= c_blk2;
          end
        end
        default: ;
      endcase
      // A start overrides whatever the engine was doing this cycle.
      if (w_start) begin
        r_msg   <= r_msg_stg;
        r_nonce <= '0;
        r_v     <= c_h0;
        r_w     <= blk1(r_msg_stg);
        r_round <= '0;
        r_state <= c_midstate;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_top_level_miner.sv
`default_nettype none
// ============================================================================
// Module   : tb_top_level_miner
// Purpose  : Directed self-checking bench for top_level_miner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_top_level_miner;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [4:0]  b_addr;
  logic [31:0] b_wdata;
  logic        b_wr, b_rd, b_cs, sel;
  int          errors = 0;
  int          checks = 0;
  logic [607:0] g_msg;
  logic [31:0]  n1;
  bit           n1_ok;

  always #5 clk = ~clk;

  top_level_miner_if bus0 ();
  top_level_miner_if bus1 ();

  assign bus0.slaveAddr       = b_addr;
  assign bus0.slaveWriteData  = b_wdata;
  assign bus0.slaveWrite      = b_wr;
  assign bus0.slaveRead       = b_rd;
  assign bus0.slaveChipSelect = b_cs & ~sel;
  assign bus1.slaveAddr       = b_addr;
  assign bus1.slaveWriteData  = b_wdata;
  assign bus1.slaveWrite      = b_wr;
  assign bus1.slaveRead       = b_rd;
  assign bus1.slaveChipSelect = b_cs & sel;

  wire [31:0] rdata = sel ? bus1.slaveReadData : bus0.slaveReadData;

  top_level_miner dut0 (.clk(clk), .n_rst(n_rst), .bus(bus0.slave));
  top_level_miner #(.MAX_NONCE(32'd3)) dut1 (.clk(clk), .n_rst(n_rst), .bus(bus1.slave));

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Byte-oriented reference SHA-256 over up to 128 bytes.
  function automatic logic [255:0] sha256(input logic [7:0] m [0:127], input int len);
    logic [7:0]  p [0:127];
    logic [31:0] w [0:63];
    logic [31:0] h [0:7];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    logic [63:0] bits;
    int nblk;
    nblk = (len + 9 + 63) / 64;
    for (int i = 0; i < 128; i++) p[i] = (i < len) ? m[i] : 8'h00;
    p[len] = 8'h80;
    bits = 64'(len) * 64'd8;
    for (int k = 0; k < 8; k++) p[nblk*64 - 1 - k] = bits[8*k +: 8];
    h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int blk = 0; blk < nblk; blk++) begin
      for (int t = 0; t < 16; t++)
        w[t] = {p[blk*64 + 4*t], p[blk*64 + 4*t + 1], p[blk*64 + 4*t + 2], p[blk*64 + 4*t + 3]};
      for (int t = 16; t < 64; t++)
        w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
             + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
        t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  // Header = 76 message bytes (big-endian) + little-endian nonce; result byte-reversed.
  function automatic logic [255:0] pow_hash(input logic [607:0] msg, input logic [31:0] n);
    logic [7:0]   hb [0:127];
    logic [255:0] d1, d2, hv;
    for (int i = 0; i < 128; i++) hb[i] = 8'h00;
    for (int i = 0; i < 76; i++) hb[i] = msg[607 - 8*i -: 8];
    hb[76] = n[7:0]; hb[77] = n[15:8]; hb[78] = n[23:16]; hb[79] = n[31:24];
    d1 = sha256(hb, 80);
    for (int i = 0; i < 128; i++) hb[i] = 8'h00;
    for (int i = 0; i < 32; i++) hb[i] = d1[255 - 8*i -: 8];
    d2 = sha256(hb, 32);
    for (int k = 0; k < 32; k++) hv[8*k +: 8] = d2[255 - 8*k -: 8];
    return hv;
  endfunction

  task automatic model_search(input logic [255:0] tgt, output logic [31:0] n, output bit ok);
    ok = 1'b0;
    n  = '0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (pow_hash(g_msg, 32'(i)) < tgt) begin
        n  = 32'(i);
        ok = 1'b1;
      end
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    b_cs = 1'b1; b_wr = 1'b1; b_addr = a; b_wdata = d;
    @(negedge clk);
    b_cs = 1'b0; b_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    b_cs = 1'b1; b_rd = 1'b1; b_addr = a;
    @(posedge clk);
    #1;
    d = rdata;
    b_cs = 1'b0; b_rd = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic [31:0] st);
    bit done;
    done = 1'b0;
    st   = 32'd2;
    for (int i = 0; i < budget && !done; i++) begin
      bus_read(5'd0, st);
      if (st != 32'd2) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done: status still %0d after %0d polls, required not 2", st, budget);
    end
  endtask

  task automatic set_target(input logic [255:0] t);
    for (int i = 0; i < 8; i++) bus_write(5'(2 + i), t[32*i +: 32]);
    bus_write(5'd1, 32'd1);
  endtask

  task automatic set_msg(input logic [607:0] m);
    for (int i = 0; i < 19; i++) bus_write(5'(11 + i), m[32*i +: 32]);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
    bus_read(5'd0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_status: got %h, required 0", d); end
    bus_read(5'd10, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_nonce: got %h, required 0", d); end
  endtask

  task automatic test_model;
    logic [7:0]   m [0:127];
    logic [255:0] h;
    for (int i = 0; i < 128; i++) m[i] = 8'h00;
    m[0] = 8'h61; m[1] = 8'h62; m[2] = 8'h63;
    h = sha256(m, 3);
    checks++;
    if (h !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) begin
      errors++; $display("FAIL model_abc: got %h, required ba7816bf...", h);
    end
  endtask

  task automatic test_regs;
    logic [31:0] d;
    bus_write(5'd9, 32'hDEADBEEF);
    bus_read(5'd9, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL reg_target_hi: got %h, required deadbeef", d); end
    bus_write(5'd29, 32'hA5A5_0F0F);
    bus_read(5'd29, d);
    checks++;
    if (d !== 32'hA5A5_0F0F) begin errors++; $display("FAIL reg_msg_hi: got %h, required a5a50f0f", d); end
    bus_write(5'd2, 32'h1357_9BDF);
    bus_read(5'd2, d);
    checks++;
    if (d !== 32'h1357_9BDF) begin errors++; $display("FAIL reg_target_lo: got %h, required 13579bdf", d); end
    bus_read(5'd1, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reg_control_read: got %h, required 0", d); end
    bus_write(5'd31, 32'h1234_5678);
    bus_read(5'd31, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reg_addr31: got %h, required 0", d); end
  endtask

  task automatic test_easy_target;
    logic [31:0] d;
    set_msg(g_msg);
    set_target({256{1'b1}});
    bus_write(5'd1, 32'd2);
    bus_read(5'd0, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL easy_busy: got %0d, required 2", d); end
    wait_done(1000, d);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL easy_found: got %0d, required 3", d); end
    bus_read(5'd10, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL easy_nonce: got %h, required 0", d); end
  endtask

  task automatic test_exhausted;
    logic [31:0] d, exp_cnt;
    sel = 1'b1;
    bus_write(5'd1, 32'd1);
    bus_write(5'd1, 32'd2);
    bus_read(5'd0, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL exh_busy: got %0d, required 2", d); end
    wait_done(2000, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL exh_status: got %0d, required 1", d); end
    bus_read(5'd10, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL exh_nonce: got %h, required 0", d); end
`ifdef MINER_HASHCOUNT_EN
    exp_cnt = 32'd4;
`else
    exp_cnt = 32'd0;
`endif
    bus_read(5'd30, d);
    checks++;
    if (d !== exp_cnt) begin errors++; $display("FAIL exh_hashcount: got %0d, required %0d", d, exp_cnt); end
    sel = 1'b0;
  endtask

  task automatic test_hash_search;
    logic [31:0] d, n2;
    bit ok2;
    model_search(256'h1 << 252, n1, n1_ok);
    checks++;
    if (!n1_ok) begin errors++; $display("FAIL model_search: no nonce below 300, required one"); end
    set_target(256'h1 << 252);
    bus_write(5'd1, 32'd2);
    wait_done(int'(n1) * 140 + 400, d);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL search_status: got %0d, required 3", d); end
    bus_read(5'd10, d);
    checks++;
    if (d !== n1) begin errors++; $display("FAIL search_nonce: got %0d, required %0d", d, n1); end
    // Raise the target and restart without rewriting the message.
    model_search(256'h1 << 254, n2, ok2);
    set_target(256'h1 << 254);
    bus_write(5'd1, 32'd2);
    wait_done(int'(n2) * 140 + 400, d);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL research_status: got %0d, required 3", d); end
    bus_read(5'd10, d);
    checks++;
    if (d !== n2) begin errors++; $display("FAIL research_nonce: got %0d, required %0d", d, n2); end
  endtask

  task automatic test_restart;
    logic [31:0] d;
    set_target(256'h1 << 252);
    bus_write(5'd1, 32'd2);
    repeat (300) @(posedge clk);
    bus_write(5'd1, 32'd2);
    bus_read(5'd0, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL restart_busy: got %0d, required 2", d); end
    wait_done(int'(n1) * 140 + 400, d);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL restart_status: got %0d, required 3", d); end
    bus_read(5'd10, d);
    checks++;
    if (d !== n1) begin errors++; $display("FAIL restart_nonce: got %0d, required %0d", d, n1); end
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    bus_write(5'd1, 32'd2);
    repeat (100) @(posedge clk);
    bus_read(5'd0, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL areset_pre_busy: got %0d, required 2", d); end
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL areset_rdata: got %h, required 0", rdata); end
    @(negedge clk);
    n_rst = 1'b1;
    bus_read(5'd0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL areset_status: got %0d, required 0", d); end
    bus_read(5'd10, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL areset_nonce: got %h, required 0", d); end
  endtask

  initial begin
    b_addr = '0; b_wdata = '0; b_wr = 1'b0; b_rd = 1'b0; b_cs = 1'b0; sel = 1'b0;
    n_rst = 1'b0; n1 = '0; n1_ok = 1'b0;
    for (int i = 0; i < 19; i++) g_msg[32*i +: 32] = 32'h1234_5678 + 32'(i) * 32'h0101_0301;
    test_reset();
    test_model();
    test_regs();
    test_easy_target();
    test_exhausted();
    test_hash_search();
    test_restart();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
